// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the parametrised register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_ZERO_IDX = 31;

  // Clear sequencer states: sweeping the array, or normal operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: owns the CLEAR/RUN state, sweep index, ready flag and
// the dropped-write pulse. Drives the clear port of the array write mux.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              wr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              run,
  output logic              ready,
  output logic              wr_dropped
);

  // Last index of the sweep; the counter is ADDR_W bits so it wraps after it.
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic              wr_dropped_q, wr_dropped_d;

  // Next-state logic: advance the sweep, restart it on request, and flag any
  // user write that cannot be honoured (sweeping, or clear wins over write).
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    ready_d      = ready_q;
    wr_dropped_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_dropped_d = wr_req;
        if (clear_req) begin
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == LAST_IDX) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d      = ST_CLEAR;
          clr_idx_d    = '0;
          ready_d      = 1'b0;
          wr_dropped_d = wr_req;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  // State, sweep index and registered outputs; reset starts a fresh sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      ready_q      <= 1'b0;
      wr_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      ready_q      <= ready_d;
      wr_dropped_q <= wr_dropped_d;
    end
  end

  assign clr_we     = (state_q == ST_CLEAR);
  assign clr_addr   = clr_idx_q;
  assign run        = (state_q == ST_RUN);
  assign ready      = ready_q;
  assign wr_dropped = wr_dropped_q;

endmodule : regfile_clear_seq

// File: rtl/regfile_param_clr.sv
// Parametrised register file: two combinational read ports, one synchronous
// write port, optional hard-zero entry, optional write->read bypass and a
// hardware clear sweep after reset or on request.
module regfile_param_clr
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_IDX  = DEF_ZERO_IDX,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Rn,
  input  logic [ADDR_W-1:0] Rm,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [DATA_W-1:0] dataWrite,
  input  logic              regWR,
  input  logic              clearReq,
  output logic [DATA_W-1:0] dataRn,
  output logic [DATA_W-1:0] dataRm,
  output logic              ready,
  output logic              wrDropped
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_IDX);
  localparam bit                ZERO_ON = (ZERO_EN != 0);
  localparam bit                BYP_ON  = (BYPASS_EN != 0);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic              user_we;
  logic              wr_live;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clearReq),
    .wr_req     (regWR),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .run        (run),
    .ready      (ready),
    .wr_dropped (wrDropped)
  );

  // A write is live when it will actually be applied this edge (RUN, no clear).
  // The hard-zero entry swallows writes silently: no storage update, no drop flag.
  always_comb begin
    wr_live = run && regWR && !clearReq;
    user_we = wr_live && !(ZERO_ON && (Rd == ZERO_A));
  end

  // Array write mux: the clear sweep owns the port while it runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (user_we) begin
      mem[Rd] <= dataWrite;
    end
  end

  // Per-port read selection: zero while sweeping, then hard-zero, bypass, array.
  function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (!run) begin
      val = '0;
    end else if (ZERO_ON && (addr == ZERO_A)) begin
      val = '0;
    end else if (BYP_ON && wr_live && (Rd == addr)) begin
      val = dataWrite;
    end else begin
      val = mem[addr];
    end
    return val;
  endfunction

  // Both read ports share the same selection so equal addresses give equal data.
  always_comb begin
    dataRn = read_sel(Rn);
    dataRm = read_sel(Rm);
  end

endmodule : regfile_param_clr
